// File: rtl/uart_line_rx_if.sv
// Byte handshake between the receive FIFO head (master) and its consumer (slave).
// Transfer happens on any cycle where m_valid && m_ready.
interface uart_line_rx_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_line_rx.sv
// UART receiver into a small byte FIFO: 8N1 by default, 8E1 when UART_LINE_RX_PARITY_EN is defined.
// Byte visible 1 cycle after the stop-bit sample; a push into a full FIFO drops the byte and sets sticky ovf.
module uart_line_rx #(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_i,
  uart_line_rx_if.master                m_if,
  output logic                          frame_err,
  output logic                          par_err,
  output logic                          ovf,
  input  logic                          ovf_clr,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [15:0] HALF_LD = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL_LD = 16'(BAUD_DIV - 1);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_LINE_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRKWAIT} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRKWAIT} state_t;
`endif

  logic       rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0] sync_vld_q;
  logic       fall_w;

  // rx_prev_q only ever holds a genuinely sampled line level, so a line held
  // low across reset release cannot look like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      sync_vld_q <= 2'b00;
      rx_prev_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rx_i;
      rx_sync_q  <= rx_meta_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      rx_prev_q  <= rx_sync_q & sync_vld_q[1];
    end
  end

  assign fall_w = rx_prev_q & ~rx_sync_q;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        frame_err_q;
  logic        cnt_zero_w;
  logic        drop_w;
  logic        push_w;

`ifdef UART_LINE_RX_PARITY_EN
  logic par_err_q;
  logic drop_q;
  assign drop_w  = drop_q;
  assign par_err = par_err_q;
`else
  assign drop_w  = 1'b0;
  assign par_err = 1'b0;
`endif

  assign cnt_zero_w = (cnt_q == 16'd0);
  assign push_w     = (state_q == STOP) && cnt_zero_w && rx_sync_q && !drop_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
`ifdef UART_LINE_RX_PARITY_EN
      par_err_q   <= 1'b0;
      drop_q      <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
`ifdef UART_LINE_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (fall_w) begin
            cnt_q   <= HALF_LD;
            state_q <= START;
          end
        end
        START: begin
          if (!cnt_zero_w) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (rx_sync_q) begin
            state_q <= IDLE;
          end else begin
            cnt_q   <= FULL_LD;
            bit_q   <= 3'd0;
`ifdef UART_LINE_RX_PARITY_EN
            drop_q  <= 1'b0;
`endif
            state_q <= DATA;
          end
        end
        DATA: begin
          if (!cnt_zero_w) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            shift_q <= {rx_sync_q, shift_q[7:1]};
            cnt_q   <= FULL_LD;
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_LINE_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end
        end
`ifdef UART_LINE_RX_PARITY_EN
        PARITY: begin
          if (!cnt_zero_w) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            if (rx_sync_q != ^shift_q) begin
              par_err_q <= 1'b1;
              drop_q    <= 1'b1;
            end
            cnt_q   <= FULL_LD;
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          if (!cnt_zero_w) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (rx_sync_q) begin
            state_q <= IDLE;
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= BRKWAIT;
          end
        end
        BRKWAIT: begin
          if (rx_sync_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_fifo_q, cnt_fifo_d;
  logic          full_w, pop_w, wr_en_w, ovf_set_w, ovf_q;

  assign full_w    = (cnt_fifo_q == DEPTH_C);
  assign pop_w     = m_if.m_valid && m_if.m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign wr_en_w   = push_w && (!full_w || pop_w);
  assign ovf_set_w = push_w && full_w && !pop_w;

  always_comb begin
    cnt_fifo_d = cnt_fifo_q;
    if (wr_en_w && !pop_w) cnt_fifo_d = cnt_fifo_q + 1'b1;
    else if (!wr_en_w && pop_w) cnt_fifo_d = cnt_fifo_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_fifo_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (wr_en_w) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_w) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_fifo_q <= cnt_fifo_d;
      ovf_q      <= ovf_set_w | (ovf_q & ~ovf_clr);
    end
  end

  assign m_if.m_data  = mem_q[rd_ptr_q];
  assign m_if.m_valid = (cnt_fifo_q != '0);
  assign frame_err    = frame_err_q;
  assign ovf          = ovf_q;
  assign busy         = (state_q != IDLE);
  assign fifo_cnt     = cnt_fifo_q;

endmodule

// File: tb/tb_uart_line_rx.sv
// Bench for uart_line_rx: directed serial frames checked every cycle against a queue-based model.
`timescale 1ns/1ps
module tb_uart_line_rx;
  localparam int BD    = 8;
  localparam int DEPTH = 4;
`ifdef UART_LINE_RX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FLEN     = FB * BD;
  // 2 sync flops + edge detect, half a start bit, then the remaining bits
  localparam int PUSH_OFS = 3 + BD / 2 + (FB - 1) * BD;
  localparam int PAR_OFS  = PUSH_OFS - BD;
  localparam int NEVER    = 32'h7fffffff;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_i = 1'b1;
  logic       ovf_clr = 1'b0;
  logic       frame_err, par_err, ovf, busy;
  logic [2:0] fifo_cnt;

  uart_line_rx_if bus ();

  uart_line_rx #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx_i(rx_i), .m_if(bus),
    .frame_err(frame_err), .par_err(par_err), .ovf(ovf), .ovf_clr(ovf_clr),
    .busy(busy), .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];
  logic [7:0] push_at[int];
  bit         ferr_at[int];
  bit         perr_at[int];
  logic       exp_ovf = 1'b0;
  int         busy_lo = -1;
  int         busy_hi = -2;
  logic [7:0] popped[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  // Model: bytes appear at their scheduled stop-sample edge, leave on accepted handshakes.
  initial begin : model_p
    bit pop;
    bit drop;
    int sz;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        sz   = exp_q.size();
        pop  = (sz > 0) && bus.m_ready;
        drop = push_at.exists(cyc) && (sz == DEPTH) && !pop;
        if (pop) void'(exp_q.pop_front());
        if (push_at.exists(cyc) && !drop) exp_q.push_back(push_at[cyc]);
        if (drop) exp_ovf = 1'b1;
        else if (ovf_clr) exp_ovf = 1'b0;
      end
      #1;
      check("m_valid", 32'(bus.m_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("m_data", 32'(bus.m_data), 32'(exp_q[0]));
      else check("m_data_known", 32'($isunknown(bus.m_data)), 32'(0));
      check("fifo_cnt", 32'(fifo_cnt), 32'(exp_q.size()));
      check("ovf", 32'(ovf), 32'(exp_ovf));
      check("frame_err", 32'(frame_err), 32'(ferr_at.exists(cyc)));
      check("par_err", 32'(par_err), 32'(perr_at.exists(cyc)));
      check("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
    end
  end

  // mode 1: m_ready pulse on the push edge; mode 2: ovf_clr pulse on the push edge
  task automatic send(input logic [7:0] d, input logic stop_b, input logic par_b,
                      input int ncyc, input int mode, input bit brk);
    logic [FB-1:0] bits;
    int            c;
`ifdef UART_LINE_RX_PARITY_EN
    bits = {stop_b, par_b, d, 1'b0};
`else
    bits = {stop_b, d, 1'b0};
`endif
    @(negedge clk);
    c = cyc;
    busy_lo = c + 3;
    busy_hi = (brk || ncyc < FLEN) ? NEVER : c + PUSH_OFS - 1;
    if (ncyc == FLEN) begin
      if (stop_b && (FB == 10 || par_b == even_par(d))) push_at[c + PUSH_OFS] = d;
      if (!stop_b) ferr_at[c + PUSH_OFS] = 1'b1;
      if (FB == 11 && par_b != even_par(d)) perr_at[c + PAR_OFS] = 1'b1;
    end
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) @(negedge clk);
      rx_i = bits[k / BD];
      if (k == PUSH_OFS - 1 && mode == 1) bus.m_ready = 1'b1;
      if (k == PUSH_OFS - 1 && mode == 2) ovf_clr = 1'b1;
      if (k == PUSH_OFS) begin
        bus.m_ready = 1'b0;
        ovf_clr     = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_i = 1'b1;
    end
  endtask

  task automatic drain(input int n);
    popped.delete();
    bus.m_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (bus.m_valid) popped.push_back(bus.m_data);
      @(negedge clk);
    end
    bus.m_ready = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("rst_m_valid", 32'(bus.m_valid), 32'(0));
    check("rst_m_data", 32'(bus.m_data), 32'(0));
    check("rst_fifo_cnt", 32'(fifo_cnt), 32'(0));
    check("rst_ovf", 32'(ovf), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_frame_err", 32'(frame_err), 32'(0));
    check("rst_par_err", 32'(par_err), 32'(0));
  endtask

  initial begin : watchdog_p
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin : stim_p
    int c;
    bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    idle(6);

    // Single byte, then pop
    send(8'h55, 1'b1, even_par(8'h55), FLEN, 0, 0);
    check("t1_valid", 32'(bus.m_valid), 32'(1));
    check("t1_data", 32'(bus.m_data), 32'h55);
    check("t1_cnt", 32'(fifo_cnt), 32'(1));
    drain(1);
    check("t1_cnt_after_pop", 32'(fifo_cnt), 32'(0));
    idle(4);

    // Overflow on the fifth byte
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 1'b1, even_par(8'(i)), FLEN, 0, 0);
      idle(4);
    end
    check("t2_cnt_full", 32'(fifo_cnt), 32'(4));
    check("t2_ovf_set", 32'(ovf), 32'(1));
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("t2_ovf_cleared", 32'(ovf), 32'(0));
    drain(6);
    check("t2_pop_count", 32'(popped.size()), 32'(4));
    for (int i = 0; i < popped.size(); i++) check("t2_pop_seq", 32'(popped[i]), 32'(i + 1));

    // Push+pop while full, then overflow coinciding with ovf_clr
    for (int i = 0; i < 4; i++) begin
      send(8'h10 + 8'(i), 1'b1, even_par(8'h10 + 8'(i)), FLEN, 0, 0);
      idle(4);
    end
    send(8'h14, 1'b1, even_par(8'h14), FLEN, 1, 0);
    check("t3_cnt_unchanged", 32'(fifo_cnt), 32'(4));
    check("t3_no_ovf", 32'(ovf), 32'(0));
    idle(4);
    send(8'h15, 1'b1, even_par(8'h15), FLEN, 2, 0);
    check("t3_ovf_beats_clr", 32'(ovf), 32'(1));
    idle(4);
    drain(6);
    check("t3_pop_count", 32'(popped.size()), 32'(4));
    for (int i = 0; i < popped.size(); i++) check("t3_pop_seq", 32'(popped[i]), 32'h11 + 32'(i));
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;

    // Framing error followed by a held-low break
    idle(4);
    send(8'hA3, 1'b0, even_par(8'hA3), FLEN, 0, 1);
    repeat (40) begin
      @(negedge clk);
      rx_i = 1'b0;
    end
    check("t4_busy_in_break", 32'(busy), 32'(1));
    check("t4_cnt", 32'(fifo_cnt), 32'(0));
    @(negedge clk);
    c = cyc;
    rx_i = 1'b1;
    busy_hi = c + 2;
    idle(6);
    check("t4_busy_released", 32'(busy), 32'(0));

    // Start-bit glitch
    @(negedge clk);
    c = cyc;
    busy_lo = c + 3;
    busy_hi = c + 6;
    rx_i = 1'b0;
    repeat (3) @(negedge clk);
    rx_i = 1'b1;
    idle(12);
    check("t5_cnt", 32'(fifo_cnt), 32'(0));
    check("t5_busy", 32'(busy), 32'(0));

    // Reset in DATA bit 4, line held low through release, then a clean byte
    send(8'hF0, 1'b1, even_par(8'hF0), 5 * BD + BD / 2, 0, 0);
    check("t6_busy_mid_frame", 32'(busy), 32'(1));
    @(negedge clk);
    rx_i = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    push_at.delete();
    ferr_at.delete();
    perr_at.delete();
    exp_ovf = 1'b0;
    busy_lo = -1;
    busy_hi = -2;
    #1;
    check_reset_vals();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_no_start_while_low", 32'(busy), 32'(0));
    idle(6);
    send(8'h3C, 1'b1, even_par(8'h3C), FLEN, 0, 0);
    check("t6_data", 32'(bus.m_data), 32'h3C);
    check("t6_cnt", 32'(fifo_cnt), 32'(1));
    drain(2);
    idle(4);

`ifdef UART_LINE_RX_PARITY_EN
    // Bad then good parity on 0x07 (odd number of ones, even-parity bit is 1)
    send(8'h07, 1'b1, 1'b0, FLEN, 0, 0);
    check("t7_bad_par_dropped", 32'(fifo_cnt), 32'(0));
    idle(4);
    send(8'h07, 1'b1, 1'b1, FLEN, 0, 0);
    check("t7_good_par_data", 32'(bus.m_data), 32'h07);
    check("t7_good_par_cnt", 32'(fifo_cnt), 32'(1));
    drain(2);
    idle(4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_line_rx.md
UART_LINE_RX -- requirements
Module: uart_line_rx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 868, clk cycles per bit (100 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_i  input  1  serial line driven by SoC uart0_tx (fpioa[1]); idles high.
REQ-006 SHALL have port m_data  output  8  head-of-FIFO byte.
REQ-007 SHALL have port m_valid  output  1  FIFO non-empty.
REQ-008 SHALL have port m_ready  input  1  consumer accepts m_data when m_valid && m_ready.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-010 SHALL have port par_err  output  1  one-cycle pulse on parity mismatch (see Configuration).
REQ-011 SHALL have port ovf  output  1  sticky overflow flag.
REQ-012 SHALL have port ovf_clr  input  1  clears ovf.
REQ-013 SHALL have port busy  output  1  high whenever FSM is not IDLE.
REQ-014 SHALL have port fifo_cnt  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-015 SHALL pass rx_i through a 2-flop synchronizer, reset to 1; all decoding uses the synchronized value.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP, BRKWAIT.
REQ-017 IDLE: synchronized rx 1->0 transition SHALL load bit counter with BAUD_DIV/2-1 and enter START.
REQ-018 START: at counter expiry, rx=1 SHALL be treated as a glitch and return to IDLE with no flag; rx=0 SHALL enter DATA with counter reloaded to BAUD_DIV-1.
REQ-019 DATA: SHALL sample at each counter expiry, shift in LSB first, reload counter; after 8th bit SHALL enter PARITY (macro) or STOP.
REQ-020 STOP: sample=1 SHALL push byte into FIFO and return to IDLE; sample=0 SHALL pulse frame_err, discard byte, enter BRKWAIT.
REQ-021 BRKWAIT: SHALL remain until synchronized rx=1, then IDLE; no start detection while in BRKWAIT.
REQ-022 m_valid SHALL assert the cycle after the stop-bit sample cycle when FIFO was empty (push latency 1).
REQ-023 Pop SHALL occur on m_valid && m_ready; m_data SHALL then present next entry the following cycle.
REQ-024 Push into full FIFO without simultaneous pop SHALL drop the byte and set ovf; FIFO contents unchanged.
REQ-025 Push and pop in same cycle while full SHALL both succeed; ovf SHALL not set; fifo_cnt unchanged.
REQ-026 ovf SHALL clear on ovf_clr; if ovf_clr coincides with a new overflow, ovf SHALL remain set.
REQ-027 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_cnt SHALL range 0..FIFO_DEPTH.
REQ-028 m_data SHALL be don't-care but stable (no X) when m_valid=0.

Reset
REQ-029 Asserting rst at any time, including mid-frame, SHALL immediately force IDLE, empty FIFO, counters 0.
REQ-030 Reset values: m_valid=0, m_data=0, frame_err=0, par_err=0, ovf=0, busy=0, fifo_cnt=0.
REQ-031 After rst deasserts with rx_i held low, no start SHALL be detected until rx returns high and falls again.

Configuration
REQ-032 Macro UART_LINE_RX_PARITY_EN defined: frame is 8E1; PARITY state samples 9th bit; mismatch vs even parity of data SHALL pulse par_err and discard byte, then proceed to STOP (stop still checked, frame_err may also pulse).
REQ-033 Macro undefined: frame is 8N1; PARITY state absent; par_err SHALL be tied 0.

Verification (BAUD_DIV=8, FIFO_DEPTH=4)
REQ-034 Send 0x55 8N1 -> m_valid rises 1 cycle after stop sample, m_data=0x55, fifo_cnt=1; m_ready=1 -> fifo_cnt=0.
REQ-035 Send 0x01,0x02,0x03,0x04,0x05 with m_ready=0 -> fifo_cnt=4, ovf=1, popped sequence 0x01..0x04; ovf_clr -> ovf=0.
REQ-036 Send 0xA3 with stop bit 0, hold rx low 40 cycles -> frame_err one pulse, fifo_cnt=0, busy stays 1 until rx high.
REQ-037 rx low for 3 cycles then high -> START returns IDLE, no push, no flags.
REQ-038 Assert rst during DATA bit 4 of 0xF0 -> outputs at reset values next cycle; following 0x3C received correctly.
REQ-039 Macro defined: send 0x07 with parity bit 0 -> par_err pulse, no push; parity bit 1 -> m_data=0x07.
